// File: rtl/rs_latch_driver_if.sv
// Button/drive bundle between the RS latch sequencer and its environment.
// RS_LATCH_DRIVER_SHADOW_CHECK_EN adds the latch feedback and the sticky mismatch flag.
interface rs_latch_driver_if;
    logic set_in;
    logic reset_in;
    logic s;
    logic r;
    logic c;
    logic busy;
    logic conflict;
    logic exp_q;
`ifdef RS_LATCH_DRIVER_SHADOW_CHECK_EN
    logic q_fb;
    logic mismatch;

    modport master (output set_in, reset_in, q_fb,
                    input  s, r, c, busy, conflict, exp_q, mismatch);
    modport slave  (input  set_in, reset_in, q_fb,
                    output s, r, c, busy, conflict, exp_q, mismatch);
`else
    modport master (output set_in, reset_in,
                    input  s, r, c, busy, conflict, exp_q);
    modport slave  (input  set_in, reset_in,
                    output s, r, c, busy, conflict, exp_q);
`endif
endinterface

// File: rtl/rs_latch_driver.sv
// Synchronises and debounces two push buttons and sequences non-overlapping S/R/C drive pulses for a gated RS latch.
// Optional feature macro: RS_LATCH_DRIVER_SHADOW_CHECK_EN (latch feedback compare, sticky mismatch flag).
module rs_latch_driver #(
    parameter int SYNC_STAGES  = 2,
    parameter int DB_CYCLES    = 4,
    parameter int PULSE_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    rs_latch_driver_if.slave  bus
);
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int PC_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Channel 0 is the set button, channel 1 the reset button.
    logic [1:0]             raw_s;
    logic [SYNC_STAGES-1:0] sync_r   [2];
    logic [DB_W-1:0]        db_cnt_r [2];
    logic [1:0]             level_r;
    logic [1:0]             level_d_r;
    logic [1:0]             req_s;

    state_t          state_r;
    logic            dir_r;
    logic [PC_W-1:0] pcnt_r;
    logic            s_r;
    logic            r_r;
    logic            c_r;
    logic            busy_r;
    logic            conflict_r;
    logic            exp_q_r;

    assign raw_s = {bus.reset_in, bus.set_in};
    assign req_s = level_r & ~level_d_r;

    // Synchroniser chains and per-button debounce counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                sync_r[i]   <= '0;
                db_cnt_r[i] <= '0;
            end
            level_r   <= 2'b00;
            level_d_r <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_r[i] <= {sync_r[i][SYNC_STAGES-2:0], raw_s[i]};
                if (sync_r[i][SYNC_STAGES-1] == level_r[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == DB_LAST) begin
                    level_r[i]  <= sync_r[i][SYNC_STAGES-1];
                    db_cnt_r[i] <= '0;
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
                end
            end
            level_d_r <= level_r;
        end
    end

    // Drive sequencer; outputs are set for the state being entered so they are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            dir_r      <= 1'b0;
            pcnt_r     <= '0;
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            c_r        <= 1'b0;
            busy_r     <= 1'b0;
            conflict_r <= 1'b0;
            exp_q_r    <= 1'b0;
        end else begin
            conflict_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    c_r    <= 1'b0;
                    pcnt_r <= '0;
                    // Reset wins a tie; the set request is discarded.
                    if (req_s[1]) begin
                        state_r    <= SETUP;
                        dir_r      <= 1'b0;
                        s_r        <= 1'b0;
                        r_r        <= 1'b1;
                        busy_r     <= 1'b1;
                        conflict_r <= req_s[0];
                    end else if (req_s[0]) begin
                        state_r <= SETUP;
                        dir_r   <= 1'b1;
                        s_r     <= 1'b1;
                        r_r     <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        s_r    <= 1'b0;
                        r_r    <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                SETUP: begin
                    state_r <= PULSE;
                    c_r     <= 1'b1;
                    pcnt_r  <= '0;
                end
                PULSE: begin
                    if (pcnt_r == PC_LAST) begin
                        state_r <= HOLD;
                        c_r     <= 1'b0;
                        exp_q_r <= dir_r;
                    end else begin
                        pcnt_r <= pcnt_r + PC_W'(1);
                    end
                end
                HOLD: begin
                    state_r <= IDLE;
                    s_r     <= 1'b0;
                    r_r     <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    s_r     <= 1'b0;
                    r_r     <= 1'b0;
                    c_r     <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s        = s_r;
    assign bus.r        = r_r;
    assign bus.c        = c_r;
    assign bus.busy     = busy_r;
    assign bus.conflict = conflict_r;
    assign bus.exp_q    = exp_q_r;

`ifdef RS_LATCH_DRIVER_SHADOW_CHECK_EN
    logic mismatch_r;

    // Sticky compare of latch feedback against the freshly updated shadow while in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_r <= 1'b0;
        end else if ((state_r == HOLD) && (bus.q_fb != exp_q_r)) begin
            mismatch_r <= 1'b1;
        end else begin
            mismatch_r <= mismatch_r;
        end
    end

    assign bus.mismatch = mismatch_r;
`endif
endmodule

// File: tb/tb_rs_latch_driver.sv
// Directed self-checking bench for rs_latch_driver (default parameters).
module tb_rs_latch_driver;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rs_latch_driver_if bus ();

    rs_latch_driver dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic in_rng(input int k, input int a, input int b);
        return (k >= a) && (k <= b);
    endfunction

    function automatic logic [5:0] outs();
        return {bus.s, bus.r, bus.c, bus.busy, bus.conflict, bus.exp_q};
    endfunction

    // Hold reset for a few cycles with buttons low; returns on the negedge where rst drops.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.set_in = 1'b0;
        bus.reset_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs() !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outs got=%b exp=000000", outs());
        end
`ifdef RS_LATCH_DRIVER_SHADOW_CHECK_EN
        checks++;
        if (bus.mismatch !== 1'b0) begin
            errors++;
            $display("FAIL reset_mismatch got=%b exp=0", bus.mismatch);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        @(negedge clk);
        rst = 1'b1;
        bus.set_in = 1'b1;
        bus.reset_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            got = outs();
            checks++;
            if (got !== 6'b000000) begin
                errors++;
                $display("FAIL reset_hold k=%0d got=%b exp=000000", k, got);
            end
        end
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            got = outs();
            checks++;
            if (got !== 6'b000000) begin
                errors++;
                $display("FAIL reset_idle k=%0d got=%b exp=000000", k, got);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clean_set();
        logic [5:0] got, exp;
        apply_reset();
        for (int k = 0; k < 16; k++) begin
            bus.set_in = 1'b1;
            exp = {in_rng(k, 7, 10), 1'b0, in_rng(k, 8, 9), in_rng(k, 7, 10), 1'b0, (k >= 10)};
            got = outs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clean_set k=%0d got=%b exp=%b", k, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bounce();
        logic [5:0] got, exp;
        apply_reset();
        for (int k = 0; k < 26; k++) begin
            bus.set_in = (k < 2) || in_rng(k, 4, 5) || (k >= 8);
            exp = {in_rng(k, 15, 18), 1'b0, in_rng(k, 16, 17), in_rng(k, 15, 18), 1'b0, (k >= 18)};
            got = outs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL bounce k=%0d got=%b exp=%b", k, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_conflict();
        logic [5:0] got, exp;
        apply_reset();
        for (int k = 0; k < 36; k++) begin
            bus.set_in   = (k < 12) || (k >= 20);
            bus.reset_in = (k >= 20);
            exp = {in_rng(k, 7, 10), in_rng(k, 27, 30),
                   in_rng(k, 8, 9) || in_rng(k, 28, 29),
                   in_rng(k, 7, 10) || in_rng(k, 27, 30),
                   (k == 27), in_rng(k, 10, 29)};
            got = outs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL conflict k=%0d got=%b exp=%b", k, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_busy_drop();
        logic [5:0] got, exp;
        apply_reset();
        for (int k = 0; k < 36; k++) begin
            bus.set_in   = (k < 12);
            bus.reset_in = in_rng(k, 2, 11) || (k >= 20);
            exp = {in_rng(k, 7, 10), in_rng(k, 27, 30),
                   in_rng(k, 8, 9) || in_rng(k, 28, 29),
                   in_rng(k, 7, 10) || in_rng(k, 27, 30),
                   1'b0, in_rng(k, 10, 29)};
            got = outs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL busy_drop k=%0d got=%b exp=%b", k, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [5:0] got, exp;
        apply_reset();
        bus.set_in = 1'b1;
        for (int k = 0; k < 9; k++) begin
            exp = {in_rng(k, 7, 10), 1'b0, in_rng(k, 8, 9), in_rng(k, 7, 10), 1'b0, (k >= 10)};
            got = outs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_pre k=%0d got=%b exp=%b", k, got, exp);
            end
            if (k < 8) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        got = outs();
        checks++;
        if (got !== 6'b000000) begin
            errors++;
            $display("FAIL mid_abort got=%b exp=000000", got);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            exp = {in_rng(k, 7, 10), 1'b0, in_rng(k, 8, 9), in_rng(k, 7, 10), 1'b0, (k >= 10)};
            got = outs();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_restart k=%0d got=%b exp=%b", k, got, exp);
            end
            @(negedge clk);
        end
    endtask

`ifdef RS_LATCH_DRIVER_SHADOW_CHECK_EN
    task automatic test_shadow();
        bus.q_fb = 1'b0;
        apply_reset();
        for (int k = 0; k < 18; k++) begin
            bus.set_in = 1'b1;
            checks++;
            if (bus.mismatch !== (k >= 11)) begin
                errors++;
                $display("FAIL shadow_bad k=%0d got=%b exp=%b", k, bus.mismatch, (k >= 11));
            end
            @(negedge clk);
        end
        apply_reset();
        for (int k = 0; k < 18; k++) begin
            bus.set_in = 1'b1;
            bus.q_fb = bus.exp_q;
            checks++;
            if (bus.mismatch !== 1'b0) begin
                errors++;
                $display("FAIL shadow_good k=%0d got=%b exp=0", k, bus.mismatch);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        errors = 0;
        bus.set_in = 1'b0;
        bus.reset_in = 1'b0;
`ifdef RS_LATCH_DRIVER_SHADOW_CHECK_EN
        bus.q_fb = 1'b0;
`endif
        test_reset();
        test_clean_set();
        test_bounce();
        test_conflict();
        test_busy_drop();
        test_reset_mid_pulse();
`ifdef RS_LATCH_DRIVER_SHADOW_CHECK_EN
        test_shadow();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
